// File: rtl/axis_tlast_gen_pkg.sv
// Shared constants and types for the AXI-Stream TLAST generator.
// Optional first-beat marker (TUSER + len_q readback) is enabled by TLAST_GEN_SOF_EN.
package axis_tlast_gen_pkg;
  localparam logic [31:0] REG_CTRL    = 32'h0;
  localparam logic [31:0] REG_PKT_LEN = 32'h4;
  localparam logic [31:0] REG_PKT_CNT = 32'h8;
  localparam logic [31:0] REG_STATUS  = 32'hC;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLR    = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_ACTIVE = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/axis_tlast_gen_axil_regs.sv
// AXI4-Lite slave and register file for the TLAST generator.
// Exports ENABLE, a one-cycle CLR pulse and PKT_LEN; reads back PKT_CNT and STATUS.
module axis_tlast_gen_axil_regs
  import axis_tlast_gen_pkg::*;
#(
  parameter int AW        = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [AW-1:0]        araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 enable,
  output logic                 clr,
  output logic [LEN_WIDTH-1:0] pkt_len,
  input  logic [31:0]          pkt_cnt,
  input  logic [31:0]          status
);
  logic [31:0] wa, ra, rd_mux;
  logic        wr_hs, rd_hs;

  // Word-align addresses; upper address bits take part in decode so aliases read 0
  assign wa    = 32'(awaddr) & ~32'h3;
  assign ra    = 32'(araddr) & ~32'h3;
  assign wr_hs = awready & awvalid & wvalid;
  assign rd_hs = arready & arvalid;
  assign bresp = RESP_OKAY;
  assign rresp = RESP_OKAY;

  always_comb begin
    rd_mux = '0;
    case (ra)
      REG_CTRL:    rd_mux[CTRL_ENABLE] = enable;
      REG_PKT_LEN: rd_mux = 32'(pkt_len);
      REG_PKT_CNT: rd_mux = pkt_cnt;
      REG_STATUS:  rd_mux = status;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      enable  <= 1'b0;
      clr     <= 1'b0;
      pkt_len <= '0;
    end else begin
      clr     <= 1'b0;
      awready <= awvalid & wvalid & ~bvalid & ~awready;
      wready  <= awvalid & wvalid & ~bvalid & ~awready;
      if (wr_hs) begin
        bvalid <= 1'b1;
        case (wa)
          REG_CTRL: if (wstrb[0]) begin
            enable <= wdata[CTRL_ENABLE];
            clr    <= wdata[CTRL_CLR];
          end
          REG_PKT_LEN:
            for (int i = 0; i < LEN_WIDTH; i++)
              if (wstrb[i/8]) pkt_len[i] <= wdata[i];
          default: ;
        endcase
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end

      arready <= arvalid & ~rvalid & ~arready;
      if (rd_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/axis_tlast_gen_cfg.sv
// AXI-Stream TLAST generator: zero-latency passthrough, TLAST on every len_q-th beat.
// Define TLAST_GEN_SOF_EN to add M_AXIS_TUSER (first beat) and len_q in STATUS[31:16].
module axis_tlast_gen_cfg
  import axis_tlast_gen_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int AXIL_ADDR_WIDTH = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [AXIL_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [31:0]                S_AXI_WDATA,
  input  logic [3:0]                 S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [AXIL_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [31:0]                S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic                       S_AXIS_TVALID,
  output logic                       S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic                       M_AXIS_TVALID,
  input  logic                       M_AXIS_TREADY,
`ifdef TLAST_GEN_SOF_EN
  output logic                       M_AXIS_TUSER,
`endif
  output logic                       M_AXIS_TLAST
);
  state_e               state, state_nxt;
  logic                 enable, clr, active, beat, tlast;
  logic [LEN_WIDTH-1:0] pkt_len, len_eff, len_q, cnt;
  logic [31:0]          pkt_cnt, status, len_q32;

  axis_tlast_gen_axil_regs #(.AW(AXIL_ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_regs (
    .clk(ACLK), .rst(ARESET),
    .awaddr(S_AXI_AWADDR), .awvalid(S_AXI_AWVALID), .awready(S_AXI_AWREADY),
    .wdata(S_AXI_WDATA), .wstrb(S_AXI_WSTRB), .wvalid(S_AXI_WVALID), .wready(S_AXI_WREADY),
    .bresp(S_AXI_BRESP), .bvalid(S_AXI_BVALID), .bready(S_AXI_BREADY),
    .araddr(S_AXI_ARADDR), .arvalid(S_AXI_ARVALID), .arready(S_AXI_ARREADY),
    .rdata(S_AXI_RDATA), .rresp(S_AXI_RRESP), .rvalid(S_AXI_RVALID), .rready(S_AXI_RREADY),
    .enable(enable), .clr(clr), .pkt_len(pkt_len), .pkt_cnt(pkt_cnt), .status(status)
  );

  assign active        = (state == RUN);
  assign len_eff       = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TVALID = S_AXIS_TVALID & active;
  assign S_AXIS_TREADY = M_AXIS_TREADY & active;
  assign beat          = M_AXIS_TVALID & M_AXIS_TREADY;
  assign tlast         = active & (cnt == len_q - LEN_WIDTH'(1));
  assign M_AXIS_TLAST  = tlast;
  assign len_q32       = 32'(len_q);

`ifdef TLAST_GEN_SOF_EN
  assign M_AXIS_TUSER = active & (cnt == '0);
  assign status = {len_q32[15:0], 14'b0, active, cnt != '0};
`else
  assign status = {16'b0, 14'b0, active, cnt != '0};
`endif

  // Disabling mid-packet lets the packet in flight finish before dropping to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN:  if (!enable && (cnt == '0 || (beat && tlast))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      pkt_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        cnt     <= '0;
        pkt_cnt <= '0;
      end else begin
        // Length is sampled only at packet start so in-flight packets keep theirs
        if ((state == IDLE && state_nxt == RUN) || (beat && cnt == '0))
          len_q <= len_eff;
        if (beat) begin
          if (tlast) begin
            cnt     <= '0;
            pkt_cnt <= pkt_cnt + 32'd1;
          end else begin
            cnt <= cnt + LEN_WIDTH'(1);
          end
        end
      end
    end
  end
endmodule
